// File: rtl/fifo2stream.sv
// Unpacks C_DDP-lane words from a latency-1 FIFO read port into a one-pixel-per-beat
// AXI4-Stream, restoring per-lane tuser/tlast. Two-word buffer (cur/nxt) hides the read latency.
module fifo2stream #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_DATA_WIDTH  = 32
) (
    input  logic                                                       clk,
    input  logic                                                       resetn,
    input  logic                                                       empty,
    input  logic [(C_DATA_WIDTH/C_PIXEL_WIDTH)*(C_PIXEL_WIDTH+2)-1:0] rd_data,
    output logic                                                       rd_en,
    output logic                                                       m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0]                                   m_axis_tdata,
    output logic                                                       m_axis_tuser,
    output logic                                                       m_axis_tlast,
    input  logic                                                       m_axis_tready
);

    localparam int C_DDP   = C_DATA_WIDTH / C_PIXEL_WIDTH;
    localparam int LANE_W  = C_PIXEL_WIDTH + 2;
    localparam int WORD_W  = C_DDP * LANE_W;
    localparam int PIDX_W  = (C_DDP > 1) ? $clog2(C_DDP) : 1;
    localparam int N_SLOTS = 1 << PIDX_W;
    localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(C_DDP - 1);

    logic [WORD_W-1:0] cur_reg, cur_next;
    logic [WORD_W-1:0] nxt_reg, nxt_next;
    logic              cur_v_reg, cur_v_next;
    logic              nxt_v_reg, nxt_v_next;
    logic              inflight_reg;
    logic [PIDX_W-1:0] pidx_reg, pidx_next;

    logic              beat;
    logic              retire;
    logic [1:0]        occupancy;
    logic [LANE_W-1:0] lane_arr [N_SLOTS];
    logic [LANE_W-1:0] lane_sel;

    assign beat      = cur_v_reg & m_axis_tready;
    assign retire    = beat & (pidx_reg == PIDX_LAST);
    assign occupancy = {1'b0, cur_v_reg} + {1'b0, nxt_v_reg} + {1'b0, inflight_reg};

    // A retiring word frees a slot this cycle, so a read may overlap it at full buffer.
    assign rd_en = resetn & ~empty & ((occupancy < 2'd2) | retire);

    always_comb begin
        cur_next   = cur_reg;
        nxt_next   = nxt_reg;
        cur_v_next = cur_v_reg;
        nxt_v_next = nxt_v_reg;
        pidx_next  = pidx_reg;

        if (beat) begin
            pidx_next = retire ? '0 : pidx_reg + PIDX_W'(1);
        end

        if (!cur_v_reg || retire) begin
            // cur is free after this edge: refill from nxt first so order is kept
            if (nxt_v_reg) begin
                cur_next   = nxt_reg;
                cur_v_next = 1'b1;
                nxt_next   = rd_data;
                nxt_v_next = inflight_reg;
            end else begin
                cur_next   = rd_data;
                cur_v_next = inflight_reg;
                nxt_v_next = 1'b0;
            end
        end else if (inflight_reg) begin
            nxt_next   = rd_data;
            nxt_v_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_v_reg    <= 1'b0;
            nxt_v_reg    <= 1'b0;
            inflight_reg <= 1'b0;
            pidx_reg     <= '0;
        end else begin
            cur_v_reg    <= cur_v_next;
            nxt_v_reg    <= nxt_v_next;
            inflight_reg <= rd_en;
            pidx_reg     <= pidx_next;
        end
    end

    always_ff @(posedge clk) begin
        cur_reg <= cur_next;
        nxt_reg <= nxt_next;
    end

    // Pad the lane table to a power of two so pidx indexes it without width games.
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_lane
        if (gi < C_DDP) begin : g_used
            assign lane_arr[gi] = cur_reg[gi*LANE_W +: LANE_W];
        end else begin : g_pad
            assign lane_arr[gi] = '0;
        end
    end

    assign lane_sel      = lane_arr[pidx_reg];
    assign m_axis_tvalid = cur_v_reg;
    assign m_axis_tdata  = lane_sel[C_PIXEL_WIDTH-1:0];
    assign m_axis_tuser  = lane_sel[C_PIXEL_WIDTH];
    assign m_axis_tlast  = lane_sel[C_PIXEL_WIDTH+1];

endmodule

// File: tb/tb_fifo2stream.sv
// Bench for fifo2stream: one instance with 4 pixels/word and one with 1 pixel/word,
// each fed by a latency-1 FIFO model and checked against an in-order pixel scoreboard.
module tb_fifo2stream;

    localparam int NINST = 2;
    localparam int MEM_D = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       resetn_a [NINST];
    logic       tready_a [NINST];
    logic       tvalid_a [NINST];
    logic [9:0] fifo_mem [NINST][MEM_D];
    int wr_pix  [NINST];
    int rd_pix  [NINST];
    int out_pix [NINST];
    int s_beats [NINST];
    int s_rds   [NINST];
    int s_first_beat [NINST];
    int s_last_beat  [NINST];
    int s_first_rd   [NINST];
    int s_last_rd    [NINST];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ddp_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [39:0] rand_word();
        return 40'({$urandom(), $urandom()});
    endfunction

    for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
        localparam int DDP = (gi == 0) ? 4 : 1;
        localparam int WW  = DDP * 10;
        logic          empty, rd_en, tvalid, tuser, tlast;
        logic [7:0]    tdata;
        logic [WW-1:0] rd_word;
        logic          held = 1'b0;
        logic [10:0]   held_val = '0;
        logic          was_rst = 1'b0;

        assign empty        = (wr_pix[gi] == rd_pix[gi]);
        assign tvalid_a[gi] = tvalid;

        fifo2stream #(
            .C_PIXEL_WIDTH(8),
            .C_DATA_WIDTH (DDP * 8)
        ) dut (
            .clk          (clk),
            .resetn       (resetn_a[gi]),
            .empty        (empty),
            .rd_data      (rd_word),
            .rd_en        (rd_en),
            .m_axis_tvalid(tvalid),
            .m_axis_tdata (tdata),
            .m_axis_tuser (tuser),
            .m_axis_tlast (tlast),
            .m_axis_tready(tready_a[gi])
        );

        // FIFO read port: data one cycle after rd_en, garbage otherwise
        always @(posedge clk) begin
            if (rd_en) begin
                for (int k = 0; k < DDP; k++)
                    rd_word[k*10 +: 10] <= fifo_mem[gi][11'(rd_pix[gi] + k)];
                rd_pix[gi] <= rd_pix[gi] + DDP;
            end else begin
                rd_word <= WW'({$urandom(), $urandom()});
            end
        end

        always @(negedge clk) begin
            if (resetn_a[gi] !== 1'b1) begin
                check_eq("rst_rd_en", 32'(rd_en), 32'd0);
                out_pix[gi] = rd_pix[gi];   // everything already read is lost
                was_rst = 1'b1;
                held = 1'b0;
            end else begin
                if (was_rst) check_eq("rst_tvalid", 32'(tvalid), 32'd0);
                was_rst = 1'b0;
                if (held) check_eq("hold_stable", 32'({tvalid, tlast, tuser, tdata}), 32'(held_val));
                if (rd_en) begin
                    check_eq("rd_while_empty", 32'(empty), 32'd0);
                    if (s_rds[gi] == 0) s_first_rd[gi] = cyc;
                    s_last_rd[gi] = cyc;
                    s_rds[gi]++;
                end
                check_eq("occupancy", 32'(rd_pix[gi] - out_pix[gi] <= 2 * DDP), 32'd1);
                if (tvalid && tready_a[gi]) begin
                    check_eq("beat_expected", 32'(out_pix[gi] < rd_pix[gi]), 32'd1);
                    check_eq("pixel", 32'({tlast, tuser, tdata}), 32'(fifo_mem[gi][11'(out_pix[gi])]));
                    out_pix[gi]++;
                    if (s_beats[gi] == 0) s_first_beat[gi] = cyc;
                    s_last_beat[gi] = cyc;
                    s_beats[gi]++;
                end
                held = tvalid && !tready_a[gi];
                held_val = {tvalid, tlast, tuser, tdata};
            end
        end
    end

    task automatic push_word(input int i, input logic [39:0] w);
        for (int k = 0; k < ddp_of(i); k++)
            fifo_mem[i][11'(wr_pix[i] + k)] = w[k*10 +: 10];
        wr_pix[i] += ddp_of(i);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_scn(input int i, output int c0);
        s_beats[i] = 0;
        s_rds[i]   = 0;
        c0 = cyc;
    endtask

    // mode 0: tready held high, 1: toggles 1,0,1,0..., 2: random
    task automatic drain(input int i, input int mode, input int budget);
        logic t = 1'b1;
        int   b = budget;
        while (out_pix[i] != wr_pix[i] && b > 0) begin
            case (mode)
                0:       tready_a[i] = 1'b1;
                1:       tready_a[i] = t;
                default: tready_a[i] = 1'($urandom_range(0, 1));
            endcase
            t = ~t;
            idle(1);
            b--;
        end
        if (b == 0) check_eq("drain_timeout", 32'(out_pix[i]), 32'(wr_pix[i]));
    endtask

    task automatic wait_pix(input int i, input int target, input int budget);
        int b = budget;
        while (out_pix[i] < target && b > 0) begin
            idle(1);
            b--;
        end
        if (b == 0) check_eq("wait_timeout", 32'(out_pix[i]), 32'(target));
    endtask

    // Timing of a burst of n words queued at cycle c0 with tready held high
    task automatic check_timing(input int i, input int c0, input int n);
        int d = ddp_of(i);
        check_eq("first_rd",   32'(s_first_rd[i] - c0),   32'd0);
        check_eq("last_rd",    32'(s_last_rd[i] - c0),    32'((n == 1) ? 0 : 1 + (n - 2) * d));
        check_eq("first_beat", 32'(s_first_beat[i] - c0), 32'd2);
        check_eq("last_beat",  32'(s_last_beat[i] - c0),  32'(2 + n * d - 1));
        check_eq("beat_count", 32'(s_beats[i]), 32'(n * d));
        check_eq("rd_count",   32'(s_rds[i]),   32'(n));
    endtask

    task automatic rand_run(input int i, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            tready_a[i] = ($urandom_range(0, 3) != 0);
            if (wr_pix[i] - out_pix[i] < 6 * ddp_of(i) && wr_pix[i] + 8 < MEM_D &&
                $urandom_range(0, 2) == 0)
                push_word(i, rand_word());
            resetn_a[i] = ($urandom_range(0, 149) != 0);
            idle(1);
        end
        resetn_a[i] = 1'b1;
        drain(i, 2, 3000);
        drain(i, 0, 200);
    endtask

    initial begin : main
        int c0;
        int base;
        logic [39:0] w3 [3];

        for (int i = 0; i < NINST; i++) begin
            resetn_a[i] = 1'b0;
            tready_a[i] = 1'b1;
        end
        // A word queued during reset must not be read until reset is released
        push_word(1, 40'h0A5);
        idle(3);
        for (int i = 0; i < NINST; i++) resetn_a[i] = 1'b1;
        drain(1, 0, 50);
        idle(3);

        // Single word with framing bits on first and last lane
        start_scn(0, c0);
        push_word(0, {10'h244, 10'h033, 10'h022, 10'h111});
        drain(0, 0, 100);
        check_eq("tvalid_after_word", 32'(tvalid_a[0]), 32'd0);
        check_timing(0, c0, 1);
        idle(3);

        // Three back-to-back words
        for (int k = 0; k < 3; k++) w3[k] = rand_word();
        start_scn(0, c0);
        for (int k = 0; k < 3; k++) push_word(0, w3[k]);
        drain(0, 0, 200);
        check_timing(0, c0, 3);
        idle(3);

        // Same words with tready toggling
        start_scn(0, c0);
        for (int k = 0; k < 3; k++) push_word(0, w3[k]);
        drain(0, 1, 400);
        check_eq("toggle_rd_count", 32'(s_rds[0]), 32'd3);
        check_eq("toggle_beats",    32'(s_beats[0]), 32'd12);
        idle(3);

        // One pixel per word, eight words
        start_scn(1, c0);
        for (int k = 0; k < 8; k++) push_word(1, 40'(k));
        drain(1, 0, 100);
        check_timing(1, c0, 8);
        idle(3);

        // Reset mid-word while the next word's read is in flight
        tready_a[0] = 1'b1;
        base = wr_pix[0];
        push_word(0, rand_word());
        wait_pix(0, base + 2, 50);
        push_word(0, rand_word());
        idle(1);
        resetn_a[0] = 1'b0;
        idle(1);
        resetn_a[0] = 1'b1;
        check_eq("rst_fifo_left", 32'(wr_pix[0] - rd_pix[0]), 32'd0);
        idle(2);
        start_scn(0, c0);
        push_word(0, rand_word());
        drain(0, 0, 100);
        check_timing(0, c0, 1);
        idle(3);

        // Stalled consumer with five words queued
        start_scn(0, c0);
        tready_a[0] = 1'b0;
        for (int k = 0; k < 5; k++) push_word(0, rand_word());
        idle(12);
        check_eq("stall_rd_count", 32'(s_rds[0]), 32'd2);
        check_eq("stall_tvalid",   32'(tvalid_a[0]), 32'd1);
        check_eq("stall_beats",    32'(s_beats[0]), 32'd0);
        drain(0, 0, 200);
        check_eq("stall_total_rd", 32'(s_rds[0]), 32'd5);
        check_eq("stall_total_px", 32'(s_beats[0]), 32'd20);
        idle(3);

        rand_run(0, 400);
        rand_run(1, 300);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
